// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//   APB3 completer in front of a DEPTH-word memory array. Word 0 is a
//   read-only ID word. A fixed number of wait states is inserted per transfer.
//   The completer flags misaligned, out-of-range and ID-write accesses with
//   pslverr on the completion cycle.
//
//   Optional feature macro: APB_PSTRB_EN
//     When defined, an APB4 byte-strobe input pstrb is added. Writes then
//     update only the strobed bytes. When undefined, every write updates the
//     full word.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0). It
//   then holds psel=1, penable=1 through the access phase. It completes in the
//   single cycle where pready=1. pready, pslverr and prdata are registered and
//   are driven to zero in every other cycle. Dropping psel or penable before
//   completion aborts the transfer without side effects.
//
// Ports
//   clk        in   clock, rising edge
//   resetn     in   asynchronous reset, active-low
//   psel       in   completer select
//   penable    in   access phase
//   pwrite     in   1 = write, 0 = read
//   paddr      in   byte address, ADDR_W bits
//   pwdata     in   write data, DATA_W bits
//   pstrb      in   byte strobes, DATA_W/8 bits (only with APB_PSTRB_EN)
//   pready     out  transfer complete (one-cycle pulse)
//   prdata     out  read data, non-zero only on a good read completion
//   pslverr    out  error, only on the completion cycle
//   dbg_state  out  FSM state: 0 = IDLE, 1 = ACCESS
// -----------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 12,
  parameter int          DEPTH       = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr,
  output logic                dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB_W = $clog2(NB);
  localparam int WI_W  = ADDR_W - LSB_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] ID_WORD = DATA_W'(ID_VALUE);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
`ifdef APB_PSTRB_EN
  logic [NB-1:0]       strb_q;
`endif

  logic [DATA_W-1:0]   mem [DEPTH];

  // Decode works on the live bus in IDLE and on the latched copy in ACCESS.
  // With zero wait states the response is registered at the setup edge, so
  // it must come from the live paddr/pwrite.
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_wr;
  logic [WI_W-1:0]     cur_wi;
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_err;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rsp_data;
  logic                setup;
  logic                access_ok;
  logic                last;
  logic                do_write;

  always_comb begin
    cur_addr  = (state == S_IDLE) ? paddr  : addr_q;
    cur_wr    = (state == S_IDLE) ? pwrite : wr_q;
    cur_wi    = cur_addr[ADDR_W-1:LSB_W];
    cur_idx   = cur_wi[IDX_W-1:0];
    cur_err   = (cur_addr[LSB_W-1:0] != '0) ||
                (32'(cur_wi) >= 32'(DEPTH)) ||
                (cur_wr && (cur_wi == '0));
    rd_word   = (cur_wi == '0) ? ID_WORD : mem[cur_idx];
    rsp_data  = (cur_err || cur_wr) ? '0 : rd_word;
    setup     = psel && !penable;
    access_ok = psel && penable;
    last      = (cnt == 4'(WAIT_CYCLES));
    do_write  = (state == S_ACCESS) && access_ok && last && wr_q && !cur_err;
  end

  assign dbg_state = (state == S_ACCESS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef APB_PSTRB_EN
      strb_q  <= '0;
`endif
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      // Response outputs are pulses; they fall back to zero unless set below.
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      case (state)
        S_IDLE: begin
          // psel && penable here is a protocol violation and is ignored.
          if (setup) begin
            state   <= S_ACCESS;
            cnt     <= '0;
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
`ifdef APB_PSTRB_EN
            strb_q  <= pstrb;
`endif
            if (WAIT_CYCLES == 0) begin
              pready  <= 1'b1;
              pslverr <= cur_err;
              prdata  <= rsp_data;
            end
          end
        end
        S_ACCESS: begin
          if (!access_ok || last) begin
            // Abort or completion; the array write itself is in the mem block.
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            // Raise pready so it is high in the cycle where cnt reaches WAIT_CYCLES.
            if ((cnt + 4'd1) == 4'(WAIT_CYCLES)) begin
              pready  <= 1'b1;
              pslverr <= cur_err;
              prdata  <= rsp_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array storage has no reset; word 0 storage is never read (ID_WORD is used).
  always_ff @(posedge clk) begin
    if (do_write) begin
`ifdef APB_PSTRB_EN
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem[cur_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
`else
      mem[cur_idx] <= wdata_q;
`endif
    end
  end

endmodule
